mem_port_arbiter: RTL and testbench

- Sequences the single byte-wide RAM port between the instruction-fetch stage (driven by pc's cur_pc) and the load/store stage.
- Serialises 1/2/4-byte accesses, assembles little-endian words and returns each with a one-cycle done pulse.
- Sits between the pc/IF logic, the MEM stage and the external RAM.

---
 rtl/mem_port_arbiter_pkg.sv | 34 +++
 rtl/mem_byte_assembler.sv | 53 +++++
 rtl/mem_port_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared codes for the byte-wide RAM port arbiter: sizes, owners, FSM states.
// IO_BASE_DEFAULT is only consumed when IO_BUFFER_STALL_EN is defined.
package mem_port_arbiter_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [1:0] BYTE = 2'd0;
  localparam logic [1:0] HALF = 2'd1;
  localparam logic [1:0] WORD = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    DONE_IF,
    DONE_LS
  } state_e;

  // Size code 3 is illegal and behaves as a word.
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      BYTE:    return 3'd1;
      HALF:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_assembler.sv
// Four little-endian byte lanes with indexed capture; the sized, extended
// result is formed from the lanes including the byte being captured this cycle.
module mem_byte_assembler
  import mem_port_arbiter_pkg::*;
#(
  parameter int LEN = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cap_en,
  input  logic [1:0]     cap_idx,
  input  logic [7:0]     cap_byte,
  input  logic [1:0]     size,
  input  logic           is_signed,
  output logic [LEN-1:0] result
);

  logic [31:0] word_d;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_q;
    logic [7:0] lane_d;

    always_comb begin
      lane_d = lane_q;
      if (cap_en && (cap_idx == 2'(gi))) begin
        lane_d = cap_byte;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lane_q <= '0;
      end else begin
        lane_q <= lane_d;
      end
    end

    assign word_d[gi*8 +: 8] = lane_d;
  end

  always_comb begin
    result = LEN'(word_d);
    case (size)
      BYTE: result = is_signed ? {{(LEN-8){word_d[7]}}, word_d[7:0]}
                               : LEN'(word_d[7:0]);
      HALF: result = is_signed ? {{(LEN-16){word_d[15]}}, word_d[15:0]}
                               : LEN'(word_d[15:0]);
      default: result = LEN'(word_d);
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF fetches and LS loads/stores onto a single byte-wide RAM port.
// Optional macro IO_BUFFER_STALL_EN holds IO-region stores while io_buffer_full.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int             LEN     = 32,
  parameter logic [LEN-1:0] IO_BASE = LEN'(IO_BASE_DEFAULT)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rdy_in,
  input  logic           flush,
  input  logic           if_req,
  input  logic [LEN-1:0] if_addr,
  output logic           if_done,
  output logic [LEN-1:0] if_data,
  input  logic           ls_req,
  input  logic           ls_we,
  input  logic [1:0]     ls_size,
  input  logic           ls_signed,
  input  logic [LEN-1:0] ls_addr,
  input  logic [LEN-1:0] ls_wdata,
  output logic           ls_done,
  output logic [LEN-1:0] ls_rdata,
  input  logic [7:0]     mem_din,
  output logic [LEN-1:0] mem_a,
  output logic [7:0]     mem_dout,
  output logic           mem_wr,
  input  logic           io_buffer_full
);

  state_e         state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic           pend_q, pend_d;
  logic [LEN-1:0] base_q, base_d;
  logic [1:0]     size_q, size_d;
  logic           signed_q, signed_d;
  logic [LEN-1:0] wdata_q, wdata_d;
  logic           owner_q, owner_d;
  logic [LEN-1:0] if_data_q, if_data_d;
  logic [LEN-1:0] ls_rdata_q, ls_rdata_d;

  logic           cap_en;
  logic [LEN-1:0] asm_result;
  logic [2:0]     n_bytes;
  logic [2:0]     last_idx;
  logic [2:0]     rd_idx;
  logic           io_hold;

`ifdef IO_BUFFER_STALL_EN
  assign io_hold = ls_req && ls_we && (ls_addr >= IO_BASE) && io_buffer_full;
`else
  logic unused_io;
  assign io_hold   = FALSE;
  assign unused_io = io_buffer_full ^ (IO_BASE == '0);
`endif

  assign n_bytes  = byte_count(size_q);
  assign last_idx = n_bytes - 3'd1;
  // cnt_q counts captured bytes; with a byte in flight the next address is one ahead.
  assign rd_idx   = pend_q ? (cnt_q + 3'd1) : cnt_q;

  mem_byte_assembler #(
    .LEN(LEN)
  ) u_asm (
    .clk      (clk),
    .rst_n    (rst_n),
    .cap_en   (cap_en),
    .cap_idx  (cnt_q[1:0]),
    .cap_byte (mem_din),
    .size     (size_q),
    .is_signed(signed_q),
    .result   (asm_result)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    base_d     = base_q;
    size_d     = size_q;
    signed_d   = signed_q;
    wdata_d    = wdata_q;
    owner_d    = owner_q;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;
    cap_en     = FALSE;

    case (state_q)
      IDLE: begin
        if (rdy_in && !io_hold) begin
          if (ls_req) begin
            base_d   = ls_addr;
            size_d   = ls_size;
            signed_d = ls_signed;
            wdata_d  = ls_wdata;
            owner_d  = OWN_LS;
            cnt_d    = '0;
            pend_d   = FALSE;
            state_d  = ls_we ? WRITE : READ;
          end else if (if_req && !flush) begin
            base_d   = if_addr;
            size_d   = WORD;
            signed_d = FALSE;
            owner_d  = OWN_IF;
            cnt_d    = '0;
            pend_d   = FALSE;
            state_d  = READ;
          end
        end
      end

      READ: begin
        if (flush && (owner_q == OWN_IF)) begin
          pend_d  = FALSE;
          state_d = IDLE;
        end else if (rdy_in) begin
          if (pend_q) begin
            cap_en = TRUE;
            cnt_d  = cnt_q + 3'd1;
            if (cnt_q == last_idx) begin
              if (owner_q == OWN_IF) begin
                if_data_d = asm_result;
                state_d   = DONE_IF;
              end else begin
                ls_rdata_d = asm_result;
                state_d    = DONE_LS;
              end
            end
          end
          pend_d = (rd_idx < n_bytes);
        end else begin
          // A stall drops the byte in flight; it is re-requested on resume.
          pend_d = FALSE;
        end
      end

      WRITE: begin
        if (rdy_in) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == last_idx) begin
            state_d = DONE_LS;
          end
        end
      end

      DONE_IF: begin
        if (flush || rdy_in) begin
          state_d = IDLE;
        end
      end

      DONE_LS: begin
        if (rdy_in) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = FALSE;
    case (state_q)
      READ: begin
        mem_a = base_q + LEN'((rd_idx < n_bytes) ? rd_idx : last_idx);
      end
      WRITE: begin
        mem_a    = base_q + LEN'(cnt_q);
        mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        mem_wr   = rdy_in;
      end
      default: ;
    endcase
  end

  assign if_done  = (state_q == DONE_IF) && rdy_in && !flush;
  assign ls_done  = (state_q == DONE_LS) && rdy_in;
  assign if_data  = if_data_q;
  assign ls_rdata = ls_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pend_q     <= FALSE;
      base_q     <= '0;
      size_q     <= BYTE;
      signed_q   <= FALSE;
      wdata_q    <= '0;
      owner_q    <= OWN_IF;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      base_q     <= base_d;
      size_q     <= size_d;
      signed_q   <= signed_d;
      wdata_q    <= wdata_d;
      owner_q    <= owner_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a byte-array memory model predicts
// every done/data result and every RAM write; a negedge monitor checks them.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy_dir = 1'b1;
  logic        rdy_rnd = 1'b1;
  logic        stall_en = 1'b0;
  logic        rdy_in;
  logic        flush = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [1:0]  ls_size = '0;
  logic        ls_signed = 1'b0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic [7:0]  mem_din = '0;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  logic        poke_en = 1'b0;
  logic [9:0]  poke_a = '0;
  logic [7:0]  poke_d = '0;

  assign rdy_in = rdy_dir && (!stall_en || rdy_rnd);

  mem_port_arbiter #(.LEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .rdy_in(rdy_in), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_signed(ls_signed),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #1;
    rdy_rnd = ($urandom_range(0, 3) != 0);
  end

  // External RAM (1 KiB, address aliased on low 10 bits), registered read.
  logic [7:0] ram [1024];
  always @(posedge clk) begin
    if (poke_en) ram[poke_a] <= poke_d;
    else if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
    mem_din <= ram[mem_a[9:0]];
  end

  // Reference model state.
  logic [7:0]  ref_mem [1024];
  logic [31:0] last_load = '0;

  typedef struct { logic [31:0] data; int cyc; bit chk; } exp_t;
  typedef struct { logic [31:0] a; logic [7:0] d; int cyc; bit chk; } wr_t;
  exp_t if_q[$];
  exp_t ls_q[$];
  wr_t  wr_q[$];

  int checks = 0;
  int failures = 0;
  int if_done_cnt = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(logic [31:0] a, logic [1:0] sz, bit sgn);
    logic [31:0] v;
    logic [31:0] ak;
    int n;
    v = '0;
    n = nbytes(sz);
    for (int k = 0; k < n; k++) begin
      ak = a + 32'(k);
      v = v | (32'(ref_mem[ak[9:0]]) << (8 * k));
    end
    if (sgn && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (sgn && n == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic model_ls(bit we, logic [1:0] sz, bit sgn, logic [31:0] a,
                          logic [31:0] wd, int start, bit chk, output int done_cyc);
    exp_t e;
    wr_t  w;
    int   n;
    n = nbytes(sz);
    if (we) begin
      for (int k = 0; k < n; k++) begin
        w.a = a + 32'(k);
        w.d = wd[8*k +: 8];
        w.cyc = start + k + 1;
        w.chk = chk;
        ref_mem[w.a[9:0]] = w.d;
        wr_q.push_back(w);
      end
      done_cyc = start + n + 1;
      e.data = last_load;
    end else begin
      e.data = ref_load(a, sz, sgn);
      last_load = e.data;
      done_cyc = start + n + 2;
    end
    e.cyc = done_cyc;
    e.chk = chk;
    ls_q.push_back(e);
  endtask

  task automatic model_if(logic [31:0] a, int start, bit chk, output int done_cyc);
    exp_t e;
    e.data = ref_load(a, 2'd2, 1'b0);
    done_cyc = start + 6;
    e.cyc = done_cyc;
    e.chk = chk;
    if_q.push_back(e);
  endtask

  task automatic wait_done(bit is_ls);
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (is_ls ? ls_done : if_done) break;
      t++;
      if (t > 300) begin
        check(is_ls ? "ls_done_timeout" : "if_done_timeout", 32'(t), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_if(logic [31:0] a);
    if_req = 1'b1;
    if_addr = a;
    wait_done(1'b0);
    if_req = 1'b0;
  endtask

  task automatic drive_ls(bit we, logic [1:0] sz, bit sgn, logic [31:0] a, logic [31:0] wd);
    ls_req = 1'b1;
    ls_we = we;
    ls_size = sz;
    ls_signed = sgn;
    ls_addr = a;
    ls_wdata = wd;
    wait_done(1'b1);
    ls_req = 1'b0;
  endtask

  task automatic poke(logic [9:0] a, logic [7:0] v);
    poke_en = 1'b1;
    poke_a = a;
    poke_d = v;
    ref_mem[a] = v;
    @(posedge clk);
    #1;
    poke_en = 1'b0;
  endtask

  task automatic run_random(int n, bit chk);
    for (int i = 0; i < n; i++) begin
      int kind, c, d, d2;
      logic [31:0] fa, la, wd;
      logic [1:0] sz;
      bit sg, we;
      kind = $urandom_range(0, 3);
      fa = 32'($urandom_range(0, 255)) << 2;
      la = 32'($urandom_range(0, 1023));
      wd = $urandom;
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      c = cyc;
      case (kind)
        0: begin
          model_if(fa, c, chk, d);
          drive_if(fa);
        end
        1, 2: begin
          model_ls(kind == 2, sz, sg, la, wd, c, chk, d);
          drive_ls(kind == 2, sz, sg, la, wd);
        end
        default: begin
          model_ls(we, sz, sg, la, wd, c, chk, d);
          model_if(fa, d + 1, chk, d2);
          fork
            drive_ls(we, sz, sg, la, wd);
            drive_if(fa);
          join
        end
      endcase
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result or a write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (if_done) begin
        exp_t e;
        if_done_cnt++;
        if (if_q.size() == 0) begin
          check("if_done_unexpected", 32'd1, 32'd0);
        end else begin
          e = if_q.pop_front();
          check("if_data", if_data, e.data);
          if (e.chk) check("if_done_cycle", 32'(cyc), 32'(e.cyc));
          $display("IF  done cyc=%0d data=%08h exp=%08h", cyc, if_data, e.data);
        end
      end
      if (ls_done) begin
        exp_t e;
        if (ls_q.size() == 0) begin
          check("ls_done_unexpected", 32'd1, 32'd0);
        end else begin
          e = ls_q.pop_front();
          check("ls_rdata", ls_rdata, e.data);
          if (e.chk) check("ls_done_cycle", 32'(cyc), 32'(e.cyc));
          $display("LS  done cyc=%0d rdata=%08h exp=%08h", cyc, ls_rdata, e.data);
        end
      end
      if (mem_wr) begin
        wr_t w;
        if (wr_q.size() == 0) begin
          check("mem_wr_unexpected", 32'd1, 32'd0);
        end else begin
          w = wr_q.pop_front();
          check("mem_wr_addr", mem_a, w.a);
          check("mem_wr_byte", 32'(mem_dout), 32'(w.d));
          if (w.chk) check("mem_wr_cycle", 32'(cyc), 32'(w.cyc));
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, d, d2, n0;
    logic [7:0] b;

    // Fill RAM and reference memory identically while reset is held.
    for (int i = 0; i < 1024; i++) begin
      b = 8'($urandom);
      poke(10'(i), b);
    end
    @(negedge clk);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_dout", 32'(mem_dout), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_if_done", 32'(if_done), 32'd0);
    check("rst_ls_done", 32'(ls_done), 32'd0);
    check("rst_if_data", if_data, 32'd0);
    check("rst_ls_rdata", ls_rdata, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fetch only.
    poke(10'h100, 8'h13); poke(10'h101, 8'h05); poke(10'h102, 8'h10); poke(10'h103, 8'h00);
    c = cyc;
    model_if(32'h100, c, 1'b1, d);
    drive_if(32'h100);
    check("fetch_word", if_data, 32'h0010_0513);

    // Simultaneous requests: load word wins, fetch follows.
    c = cyc;
    model_ls(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, c, 1'b1, d);
    model_if(32'h104, d + 1, 1'b1, d2);
    fork
      drive_ls(1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
      drive_if(32'h104);
    join

    // Signed and unsigned narrow loads.
    poke(10'h040, 8'h80);
    poke(10'h044, 8'h01); poke(10'h045, 8'h80);
    c = cyc;
    model_ls(1'b0, 2'd0, 1'b1, 32'h40, 32'h0, c, 1'b1, d);
    drive_ls(1'b0, 2'd0, 1'b1, 32'h40, 32'h0);
    check("load_byte_signed", ls_rdata, 32'hFFFF_FF80);
    c = cyc;
    model_ls(1'b0, 2'd1, 1'b0, 32'h44, 32'h0, c, 1'b1, d);
    drive_ls(1'b0, 2'd1, 1'b0, 32'h44, 32'h0);
    check("load_half_unsigned", ls_rdata, 32'h0000_8001);

    // Store half, then read it back; ls_rdata must be unchanged by the store.
    c = cyc;
    model_ls(1'b1, 2'd1, 1'b0, 32'h300, 32'hDEAD_BEEF, c, 1'b1, d);
    drive_ls(1'b1, 2'd1, 1'b0, 32'h300, 32'hDEAD_BEEF);
    check("store_keeps_rdata", ls_rdata, 32'h0000_8001);
    c = cyc;
    model_ls(1'b0, 2'd1, 1'b0, 32'h300, 32'h0, c, 1'b1, d);
    drive_ls(1'b0, 2'd1, 1'b0, 32'h300, 32'h0);
    check("store_readback", ls_rdata, 32'h0000_BEEF);

    // Address wrap across 0xFFFFFFFF for store and load.
    c = cyc;
    model_ls(1'b1, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h1234_5678, c, 1'b1, d);
    drive_ls(1'b1, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h1234_5678);
    c = cyc;
    model_ls(1'b0, 2'd3, 1'b1, 32'hFFFF_FFFE, 32'h0, c, 1'b1, d);
    drive_ls(1'b0, 2'd3, 1'b1, 32'hFFFF_FFFE, 32'h0);
    check("wrap_load_word", ls_rdata, 32'h1234_5678);

    // Three-cycle stall in the middle of a fetch.
    c = cyc;
    model_if(32'h100, c + 4, 1'b1, d);
    fork
      drive_if(32'h100);
      begin
        repeat (3) @(posedge clk);
        #1 rdy_dir = 1'b0;
        repeat (3) @(posedge clk);
        #1 rdy_dir = 1'b1;
      end
    join
    check("stall_fetch_word", if_data, 32'h0010_0513);

    // Flush in cycle 2 of a fetch: no if_done, next load starts from IDLE.
    n0 = if_done_cnt;
    if_req = 1'b1;
    if_addr = 32'h104;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    if_req = 1'b0;
    c = cyc;
    model_ls(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, c, 1'b1, d);
    drive_ls(1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
    check("flush_no_if_done", 32'(if_done_cnt), 32'(n0));

    // IO-region store against a full IO buffer.
    c = cyc;
    io_buffer_full = 1'b1;
`ifdef IO_BUFFER_STALL_EN
    model_ls(1'b1, 2'd2, 1'b0, 32'h3_0000, 32'hCAFE_F00D, c + 5, 1'b1, d);
    fork
      drive_ls(1'b1, 2'd2, 1'b0, 32'h3_0000, 32'hCAFE_F00D);
      begin
        repeat (5) @(posedge clk);
        #1 io_buffer_full = 1'b0;
      end
    join
`else
    model_ls(1'b1, 2'd2, 1'b0, 32'h3_0000, 32'hCAFE_F00D, c, 1'b1, d);
    drive_ls(1'b1, 2'd2, 1'b0, 32'h3_0000, 32'hCAFE_F00D);
    io_buffer_full = 1'b0;
`endif

    // Random traffic: timed without stalls, then untimed with random stalls.
    run_random(150, 1'b1);
    stall_en = 1'b1;
    run_random(150, 1'b0);
    stall_en = 1'b0;

    repeat (10) @(posedge clk);
    #1;
    check("if_queue_drained", 32'(if_q.size()), 32'd0);
    check("ls_queue_drained", 32'(ls_q.size()), 32'd0);
    check("wr_queue_drained", 32'(wr_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
